// File: rtl/decoder_onehot_seq_if.sv
// Handshake bundle for decoder_onehot_seq: request side (in_*), scan control
// (scan_*) and the registered one-hot output beat (out_*).
// master = the agent driving requests and consuming beats; slave = the decoder.
interface decoder_onehot_seq_if #(
    parameter int SEL_W = 5
);
    localparam int OUT_W = 1 << SEL_W;

    logic             in_valid;
    logic             in_ready;
    logic [SEL_W-1:0] in_sel;
    logic             in_en;
    logic             scan_start;
    logic             scan_busy;
    logic             scan_done;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_onehot;
    logic [SEL_W-1:0] out_sel;

    modport master (
        output in_valid, in_sel, in_en, scan_start, out_ready,
        input  in_ready, scan_busy, scan_done, out_valid, out_onehot, out_sel
    );

    modport slave (
        input  in_valid, in_sel, in_en, scan_start, out_ready,
        output in_ready, scan_busy, scan_done, out_valid, out_onehot, out_sel
    );
endinterface

// File: rtl/decoder_onehot_seq.sv
// decoder_onehot_seq: pipelined index-to-one-hot decoder for the register-file
// write-enable path, with a built-in scan sequencer that emits every one-hot
// code in ascending order (one per accepted output slot).
// Optional feature macro: DECODER_STATS_EN adds stats_clr / beat_cnt[15:0],
// a saturating count of output handshakes.
module decoder_onehot_seq #(
    parameter int SEL_W     = 5,
    parameter bit ZERO_MASK = 1'b1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    decoder_onehot_seq_if.slave    bus
`ifdef DECODER_STATS_EN
    ,
    input  logic                   stats_clr,
    output logic [15:0]            beat_cnt
`endif
);
    localparam int OUT_W = 1 << SEL_W;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    // First scan index skips the hard-wired $r0 when it is masked.
    localparam logic [SEL_W-1:0] SCAN_FIRST = ZERO_MASK ? SEL_W'(1) : '0;
    localparam logic [SEL_W-1:0] SCAN_LAST  = '1;
    localparam logic [OUT_W-1:0] BIT0_MASK  = ZERO_MASK ? ~OUT_W'(1) : '1;

    logic [0:0]       r_state;
    logic [SEL_W-1:0] r_scan_idx;
    logic             r_out_valid;
    logic [OUT_W-1:0] r_out_onehot;
    logic [SEL_W-1:0] r_out_sel;
    logic             r_scan_done;

    logic             w_slot_free;
    logic             w_in_ready;
    logic             w_dec_fire;
    logic             w_scan_fire;
    logic             w_scan_end;
    logic             w_load;
    logic [SEL_W-1:0] w_load_sel;
    logic [OUT_W-1:0] w_load_onehot;

    // The output register can take a new beat when empty or draining this cycle.
    assign w_slot_free = !r_out_valid || bus.out_ready;
    // scan_start wins over a same-cycle request; no path from in_valid.
    assign w_in_ready  = (r_state == ST_IDLE) && !bus.scan_start && w_slot_free;
    assign w_dec_fire  = bus.in_valid && w_in_ready;
    assign w_scan_fire = (r_state == ST_SCAN) && w_slot_free;
    assign w_scan_end  = w_scan_fire && (r_scan_idx == SCAN_LAST);
    assign w_load      = w_dec_fire || w_scan_fire;

    // Select the beat to load: scan index while scanning, else the decoded request.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_load_sel    = bus.in_sel;
        w_load_onehot = '0;
        if (r_state == ST_SCAN) begin
            w_load_sel    = r_scan_idx;
            w_load_onehot = OUT_W'(1) << r_scan_idx;
        end else if (bus.in_en) begin
            w_load_onehot = OUT_W'(1) << bus.in_sel;
        end
        w_load_onehot = w_load_onehot & BIT0_MASK;
    end

    // Scan sequencer: IDLE <-> SCAN, index advances once per loaded scan beat.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_scan_idx <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.scan_start) begin
                        r_state    <= ST_SCAN;
                        r_scan_idx <= SCAN_FIRST;
                    end
                end
                ST_SCAN: begin
                    if (w_scan_fire) begin
                        if (r_scan_idx == SCAN_LAST) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_scan_idx <= r_scan_idx + SEL_W'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Output beat register: load on any fire, otherwise drop valid once taken.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid  <= 1'b0;
            r_out_onehot <= '0;
            r_out_sel    <= '0;
        end else if (w_load) begin
            r_out_valid  <= 1'b1;
            r_out_onehot <= w_load_onehot;
            r_out_sel    <= w_load_sel;
        end else if (bus.out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    // One-cycle end-of-scan pulse, aligned with the last scan beat.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_scan_done <= 1'b0;
        end else begin
            r_scan_done <= w_scan_end;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.scan_busy  = (r_state == ST_SCAN);
    assign bus.scan_done  = r_scan_done;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_onehot = r_out_onehot;
    assign bus.out_sel    = r_out_sel;

`ifdef DECODER_STATS_EN
    logic [15:0] r_beat_cnt;

    // Saturating handshake counter; clear beats a same-cycle increment.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_beat_cnt <= '0;
        end else if (stats_clr) begin
            r_beat_cnt <= '0;
        end else if (r_out_valid && bus.out_ready && (r_beat_cnt != 16'hFFFF)) begin
            r_beat_cnt <= r_beat_cnt + 16'd1;
        end
    end

    assign beat_cnt = r_beat_cnt;
`endif
endmodule

// File: tb/tb_decoder_onehot_seq.sv
// Bench for decoder_onehot_seq (SEL_W=5, ZERO_MASK=1): directed literal checks
// plus randomized traffic compared every cycle against a beat-level model.
module tb_decoder_onehot_seq;
    localparam int SEL_W     = 5;
    localparam int OUT_W     = 1 << SEL_W;
    localparam bit ZERO_MASK = 1'b1;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   total   = 0;
    int   bad     = 0;
    bit   check_en = 1'b0;

    decoder_onehot_seq_if #(.SEL_W(SEL_W)) bus();

`ifdef DECODER_STATS_EN
    logic        stats_clr = 1'b0;
    logic [15:0] beat_cnt;
`endif

    decoder_onehot_seq #(.SEL_W(SEL_W), .ZERO_MASK(ZERO_MASK)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef DECODER_STATS_EN
        ,
        .stats_clr (stats_clr),
        .beat_cnt  (beat_cnt)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit               m_valid;
    bit               m_scan;
    bit               m_done;
    logic [OUT_W-1:0] m_onehot;
    logic [SEL_W-1:0] m_sel;
    int               scan_q[$];
`ifdef DECODER_STATS_EN
    int               m_cnt;
`endif

    function automatic logic [OUT_W-1:0] code_of(input int idx, input bit en);
        longint v;
        v = en ? (longint'(1) << idx) : longint'(0);
        if (ZERO_MASK) v = v & ~longint'(1);
        return v[OUT_W-1:0];
    endfunction

    function automatic bit exp_ready();
        return !m_scan && !bus.scan_start && (!m_valid || bus.out_ready);
    endfunction

    always @(posedge clock) begin
        bit free;
        int idx;
        if (!reset_n) begin
            m_valid  = 1'b0;
            m_scan   = 1'b0;
            m_done   = 1'b0;
            m_onehot = '0;
            m_sel    = '0;
            scan_q.delete();
`ifdef DECODER_STATS_EN
            m_cnt    = 0;
`endif
        end else begin
            free = !m_valid || bus.out_ready;
`ifdef DECODER_STATS_EN
            if (stats_clr) m_cnt = 0;
            else if (m_valid && bus.out_ready && m_cnt < 65535) m_cnt++;
`endif
            m_done = 1'b0;
            if (free) m_valid = 1'b0;
            if (m_scan) begin
                if (free) begin
                    idx      = scan_q.pop_front();
                    m_sel    = idx[SEL_W-1:0];
                    m_onehot = code_of(idx, 1'b1);
                    m_valid  = 1'b1;
                    if (scan_q.size() == 0) begin
                        m_scan = 1'b0;
                        m_done = 1'b1;
                    end
                end
            end else if (bus.scan_start) begin
                m_scan = 1'b1;
                for (int i = (ZERO_MASK ? 1 : 0); i < OUT_W; i++) scan_q.push_back(i);
            end else if (bus.in_valid && free) begin
                m_sel    = bus.in_sel;
                m_onehot = code_of(int'(bus.in_sel), bus.in_en);
                m_valid  = 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge clock) begin
        if (check_en && reset_n) begin
            check("in_ready", 64'(bus.in_ready), 64'(exp_ready()));
            check("out_valid", 64'(bus.out_valid), 64'(m_valid));
            if (m_valid) begin
                check("out_onehot", 64'(bus.out_onehot), 64'(m_onehot));
                check("out_sel", 64'(bus.out_sel), 64'(m_sel));
            end
            check("scan_busy", 64'(bus.scan_busy), 64'(m_scan));
            check("scan_done", 64'(bus.scan_done), 64'(m_done));
`ifdef DECODER_STATS_EN
            check("beat_cnt", 64'(beat_cnt), 64'(m_cnt));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid   = 1'b0;
        bus.in_sel     = '0;
        bus.in_en      = 1'b0;
        bus.scan_start = 1'b0;
        bus.out_ready  = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cyc, done_cyc, beats, exp_sel, first_c, last_c;
        bit found;

        idle_inputs();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        check("rst_in_ready_during", 64'(bus.in_ready), 64'd1);
        #1 reset_n = 1'b1;
        @(negedge clock);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_onehot", 64'(bus.out_onehot), 64'd0);
        check("rst_out_sel", 64'(bus.out_sel), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_scan_busy", 64'(bus.scan_busy), 64'd0);
        check("rst_scan_done", 64'(bus.scan_done), 64'd0);
        check_en = 1'b1;

        // Decode 17, then 0 (masked $r0 gives a valid all-zero beat).
        cycle();
        bus.in_valid = 1'b1; bus.in_sel = 5'd17; bus.in_en = 1'b1; bus.out_ready = 1'b1;
        cycle();
        bus.in_sel = 5'd0;
        @(negedge clock);
        check("dec17_onehot", 64'(bus.out_onehot), 64'h0002_0000);
        check("dec17_sel", 64'(bus.out_sel), 64'd17);
        check("dec17_valid", 64'(bus.out_valid), 64'd1);
        cycle();
        bus.in_sel = 5'd3;
        @(negedge clock);
        check("dec0_onehot", 64'(bus.out_onehot), 64'd0);
        check("dec0_valid", 64'(bus.out_valid), 64'd1);

        // Backpressure on index 3, then same-cycle replacement by index 9.
        cycle();
        bus.out_ready = 1'b0; bus.in_sel = 5'd9;
        repeat (4) begin
            @(negedge clock);
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
            check("bp_onehot", 64'(bus.out_onehot), 64'h8);
            check("bp_sel", 64'(bus.out_sel), 64'd3);
            cycle();
        end
        bus.out_ready = 1'b1;
        @(negedge clock);
        check("bp_release_ready", 64'(bus.in_ready), 64'd1);
        cycle();
        bus.in_valid = 1'b0;
        @(negedge clock);
        check("bp_next_onehot", 64'(bus.out_onehot), 64'h200);
        check("bp_next_sel", 64'(bus.out_sel), 64'd9);

        // Full-rate scan.
        cycle();
        bus.scan_start = 1'b1;
        cycle();
        bus.scan_start = 1'b0;
        busy_cyc = 0; done_cyc = 0; beats = 0; exp_sel = 1; found = 1'b1;
        first_c = -1; last_c = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (bus.scan_busy) busy_cyc++;
            if (bus.scan_done) done_cyc++;
            if (bus.out_valid) begin
                if (int'(bus.out_sel) != exp_sel) found = 1'b0;
                if (first_c < 0) first_c = c;
                last_c = c;
                exp_sel++;
                beats++;
            end
            cycle();
        end
        check("scan_beats", 64'(beats), 64'd31);
        check("scan_in_order", 64'(found), 64'd1);
        check("scan_no_gaps", 64'(last_c - first_c), 64'd30);
        check("scan_busy_cycles", 64'(busy_cyc), 64'd31);
        check("scan_done_cycles", 64'(done_cyc), 64'd1);

        // Collision: scan_start and in_valid together in IDLE.
        bus.in_valid = 1'b1; bus.in_sel = 5'd4; bus.in_en = 1'b1; bus.scan_start = 1'b1;
        @(negedge clock);
        check("coll_in_ready", 64'(bus.in_ready), 64'd0);
        cycle();
        bus.in_valid = 1'b0; bus.scan_start = 1'b0;
        @(negedge clock);
        check("coll_out_valid", 64'(bus.out_valid), 64'd0);
        check("coll_scan_busy", 64'(bus.scan_busy), 64'd1);

        // Scan under random backpressure, with an ignored scan_start mid-way.
        beats = 0; exp_sel = 1; found = 1'b1;
        for (int c = 0; c < 200; c++) begin
            cycle();
            bus.out_ready  = 1'($urandom_range(0, 1));
            bus.scan_start = (c == 10);
            @(negedge clock);
            if (bus.out_valid && bus.out_ready) begin
                if (int'(bus.out_sel) != exp_sel) found = 1'b0;
                exp_sel++;
                beats++;
            end
        end
        check("bpscan_beats", 64'(beats), 64'd31);
        check("bpscan_in_order", 64'(found), 64'd1);
        cycle();
        bus.out_ready = 1'b1; bus.scan_start = 1'b0;

        // Reset asserted while the scan shows index 12.
        cycle();
        bus.scan_start = 1'b1;
        cycle();
        bus.scan_start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clock);
            if (bus.out_valid && bus.out_sel == 5'd12) begin
                found = 1'b1;
                break;
            end
            cycle();
        end
        check("rst12_reached", 64'(found), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rst12_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst12_onehot", 64'(bus.out_onehot), 64'd0);
        check("rst12_sel", 64'(bus.out_sel), 64'd0);
        check("rst12_busy", 64'(bus.scan_busy), 64'd0);
        check("rst12_done", 64'(bus.scan_done), 64'd0);
        check("rst12_in_ready", 64'(bus.in_ready), 64'd1);
`ifdef DECODER_STATS_EN
        check("rst12_beat_cnt", 64'(beat_cnt), 64'd0);
`endif
        repeat (2) @(negedge clock);
        #2 reset_n = 1'b1;
        @(negedge clock);
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("post_rst_busy", 64'(bus.scan_busy), 64'd0);
        check("post_rst_valid", 64'(bus.out_valid), 64'd0);

        // Randomized traffic, checked each cycle by the model.
        for (int c = 0; c < 1500; c++) begin
            cycle();
            bus.in_valid   = 1'($urandom_range(0, 1));
            bus.in_sel     = SEL_W'($urandom_range(0, OUT_W - 1));
            bus.in_en      = ($urandom_range(0, 3) != 0);
            bus.out_ready  = ($urandom_range(0, 3) != 0);
            bus.scan_start = ($urandom_range(0, 99) == 0);
`ifdef DECODER_STATS_EN
            stats_clr      = ($urandom_range(0, 63) == 0);
`endif
        end
        cycle();
        idle_inputs();
        repeat (3) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/decoder_onehot_seq.md
# decoder_onehot_seq

Parametrised, pipelined index-to-one-hot decoder for the register-file write-enable path. It turns a SEL_W-bit register index into a registered 2^SEL_W-bit one-hot strobe, using a valid/ready handshake on both sides. A built-in scan sequencer emits every one-hot code in order, one per beat, so the register file can be cleared or initialised without an external counter.

## Interface
Parameters:
- SEL_W, default 5: index width. OUT_W = 2^SEL_W is derived internally and not overridable.
- ZERO_MASK, default 1: 1 forces output bit 0 low in every beat (hard-wired $r0); 0 treats index 0 like any other index.

Ports:
- clock, in, 1: sole clock; all state updates on the rising edge.
- reset_n, in, 1: asynchronous, active-low reset.
- in_valid, in, 1: request to decode in_sel.
- in_ready, out, 1: decoder accepts the request this cycle.
- in_sel, in, SEL_W: index to decode.
- in_en, in, 1: 0 produces an all-zero one-hot (bubble beat).
- scan_start, in, 1: single-cycle request to start a scan.
- scan_busy, out, 1: scan in progress.
- scan_done, out, 1: one-cycle pulse at scan end.
- out_valid, out, 1: output beat valid.
- out_ready, in, 1: consumer takes the beat.
- out_onehot, out, OUT_W: registered one-hot (or zero) strobe.
- out_sel, out, SEL_W: index carried with the beat.

## Operation
- FSM states: IDLE and SCAN. Reset state is IDLE.
- Output slot is free when `!out_valid || out_ready`.
- Input acceptance: `in_ready = (state==IDLE) && !scan_start && slot free`.
  - Purely combinational; no path from in_valid.
  - Reads 1 immediately after reset.
- Decode beat, when `in_valid && in_ready`:
  - out_sel ← in_sel.
  - out_onehot ← `in_en ? (1<<in_sel) : 0`, with bit 0 cleared when ZERO_MASK=1.
  - out_valid ← 1.
- out_valid clears when `out_valid && out_ready` and no new beat loads in the same cycle.
- Full throughput: a new beat may load in the same cycle the old beat leaves.
- Output stability: out_onehot and out_sel hold steady while `out_valid && !out_ready`.
- Scan start:
  - `scan_start` in IDLE → SCAN; scan_idx ← (ZERO_MASK ? 1 : 0).
  - scan_start has priority over in_valid in the same cycle; the input is not accepted.
  - scan_start in SCAN is ignored.
- Scan beats:
  - In SCAN, each cycle the slot is free, load out_sel = scan_idx, out_onehot = 1<<scan_idx, out_valid = 1, then increment scan_idx.
  - in_en is ignored during scan.
- Scan end:
  - The load of index OUT_W-1 moves the FSM to IDLE and sets scan_done for exactly the next cycle.
  - scan_idx never wraps.
- Reset mid-operation: any in-flight beat or scan is abandoned and every output returns to its reset value.

## Timing
- Reset values: out_valid=0, out_onehot=0, out_sel=0, scan_busy=0, scan_done=0, state=IDLE, scan_idx=0.
- Latency: a beat accepted on edge k is visible on out_* after edge k (1 cycle).
- Throughput: 1 beat/cycle while out_ready=1.
- scan_busy is registered: high from the edge that samples scan_start to the edge that loads the last index.
- Scan length: OUT_W-ZERO_MASK beats, lasting (OUT_W-ZERO_MASK) cycles when out_ready is held high.
- Backpressure stretches the scan and never drops or repeats an index.

## Configuration
- DECODER_STATS_EN defined:
  - Adds output `beat_cnt[15:0]`: counts output handshakes (`out_valid && out_ready`), saturates at 16'hFFFF, reset to 0.
  - Adds input `stats_clr`: synchronous clear, which takes priority over an increment in the same cycle.
- DECODER_STATS_EN undefined: neither port exists and no counter logic is generated.

## Test plan
- Reset release with SEL_W=5, ZERO_MASK=1 → out_valid=0, out_onehot=0, in_ready=1.
- Decode, out_ready=1: in_sel=5'd17, in_en=1 → next cycle out_onehot=32'h0002_0000, out_sel=17. Then in_sel=0 → out_onehot=0, out_valid=1.
- Backpressure: load in_sel=3, hold out_ready=0 for 4 cycles → in_ready=0, out_onehot=32'h8 stable. Release out_ready → next beat accepted the same cycle.
- Scan with out_ready=1, ZERO_MASK=1 → 31 consecutive beats, out_sel 1..31. scan_busy high for 31 cycles; scan_done high for 1 cycle. Toggling out_ready randomly must still give no gaps and no repeats.
- Collision: scan_start and in_valid in the same IDLE cycle → input not accepted (in_ready=0). scan_start during SCAN → scan not restarted.
- Reset asserted at scan index 12 → all outputs zero asynchronously; after release, in_ready=1 and state is IDLE. With DECODER_STATS_EN, beat_cnt=0.
